// File: rtl/digit_serial_adder.sv
`timescale 1ns/1ps
// digit_serial_adder
// Multi-cycle adder: a + b + cin over WIDTH bits, DIGIT bits per clock.
// One DIGIT-wide ripple slice is reused every cycle and the inter-digit carry
// is held in a register. start is honoured only in IDLE. done pulses for one
// cycle when sum/cout/ovf load; those outputs then hold until the next
// completion or reset.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ripple-adds one digit. Packs {carry into digit MSB, carry out, digit sum}.
  // The carry into the MSB is needed for the signed-overflow flag.
  function automatic logic [DIGIT+1:0] add_digit(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             c
  );
    logic [DIGIT-1:0] s;
    logic             cr;
    logic             cm;
    s  = '0;
    cr = c;
    cm = c;
    for (int i = 0; i < DIGIT; i++) begin
      cm   = cr;
      s[i] = x[i] ^ y[i] ^ cr;
      cr   = (x[i] & y[i]) | (x[i] & cr) | (y[i] & cr);
    end
    return {cm, cr, s};
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic             load_s;
  logic             step_s;
  logic             finish_s;
  logic [DIGIT+1:0] dig_s;
  logic [WIDTH-1:0] sum_nx_s;

  // Digit slice on the low digit of the operand shift registers; the new
  // digit enters the top of the sum shift register.
  always_comb begin
    dig_s    = add_digit(a_sh_r[DIGIT-1:0], b_sh_r[DIGIT-1:0], carry_r);
    sum_nx_s = WIDTH'({dig_s[DIGIT-1:0], sum_sh_r} >> DIGIT);
  end

  // Next-state and control decode for the IDLE/RUN sequencer.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s     = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == CW'(NDIG - 1)) begin
          finish_s   = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, per-digit shifting and result/flag loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == RUN);
      done_r <= finish_s;
      if (load_s) begin
        a_sh_r   <= a;
        b_sh_r   <= b;
        carry_r  <= cin;
        cnt_r    <= '0;
        sum_sh_r <= '0;
      end else if (step_s) begin
        a_sh_r   <= a_sh_r >> DIGIT;
        b_sh_r   <= b_sh_r >> DIGIT;
        carry_r  <= dig_s[DIGIT];
        cnt_r    <= cnt_r + CW'(1);
        sum_sh_r <= sum_nx_s;
      end
      if (finish_s) begin
        sum_r  <= sum_nx_s;
        cout_r <= dig_s[DIGIT];
        ovf_r  <= dig_s[DIGIT] ^ dig_s[DIGIT+1];
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
`timescale 1ns/1ps
// Directed bench for digit_serial_adder: main instance DIGIT=4, plus DIGIT=1
// and DIGIT=16 instances sharing the same stimulus for the latency sweep.
module tb_digit_serial_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;

  logic        busy4, done4, cout4, ovf4;
  logic [15:0] sum4;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int vec_cnt;
  int err_cnt;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the negedge after the accept edge.
  task automatic do_start(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (sum4 !== 16'h0000 || cout4 !== 1'b0 || ovf4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset d4: sum=%h cout=%b ovf=%b busy=%b done=%b, expected all zero",
               sum4, cout4, ovf4, busy4, done4);
    end
    vec_cnt++;
    if (sum1 !== 16'h0000 || busy1 !== 1'b0 || sum16 !== 16'h0000 || busy16 !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset d1/d16: sum1=%h busy1=%b sum16=%h busy16=%b, expected zero",
               sum1, busy1, sum16, busy16);
    end
    rst = 1'b0;
  endtask

  task automatic test_simple();
    do_start(16'h0002, 16'h0002, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      if (n > 1) @(negedge clk);
      vec_cnt++;
      if (busy4 !== (n <= 4) || done4 !== (n == 5)) begin
        err_cnt++;
        $display("FAIL simple_handshake n=%0d: busy=%b done=%b, expected busy=%b done=%b",
                 n, busy4, done4, (n <= 4), (n == 5));
      end
      if (n == 5) begin
        vec_cnt++;
        if (sum4 !== 16'h0004 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
          err_cnt++;
          $display("FAIL simple_result: sum=%h cout=%b ovf=%b, expected 0004 0 0", sum4, cout4, ovf4);
        end
      end
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (sum4 !== 16'h0004 || done4 !== 1'b0) begin
      err_cnt++;
      $display("FAIL simple_hold: sum=%h done=%b, expected 0004 0", sum4, done4);
    end
  endtask

  task automatic test_carry_ripple();
    do_start(16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    vec_cnt++;
    if (sum4 !== 16'h0004 || busy4 !== 1'b1) begin
      err_cnt++;
      $display("FAIL ripple_hold_in_run: sum=%h busy=%b, expected 0004 1", sum4, busy4);
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (done4 !== 1'b1 || sum4 !== 16'h0000 || cout4 !== 1'b1 || ovf4 !== 1'b0) begin
      err_cnt++;
      $display("FAIL ripple_result: done=%b sum=%h cout=%b ovf=%b, expected 1 0000 1 0",
               done4, sum4, cout4, ovf4);
    end
  endtask

  task automatic test_overflow();
    do_start(16'h7FFF, 16'h0001, 1'b0);
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (done4 !== 1'b1 || sum4 !== 16'h8000 || cout4 !== 1'b0 || ovf4 !== 1'b1) begin
      err_cnt++;
      $display("FAIL overflow_result: done=%b sum=%h cout=%b ovf=%b, expected 1 8000 0 1",
               done4, sum4, cout4, ovf4);
    end
  endtask

  task automatic test_isolation();
    int ndone;
    int first_n;
    ndone = 0;
    first_n = -1;
    do_start(16'h0009, 16'h000A, 1'b1);
    for (int n = 1; n <= 9; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 2) begin a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1; end
      if (n == 4) start = 1'b0;
      if (done4 === 1'b1) begin
        ndone++;
        if (first_n < 0) first_n = n;
        vec_cnt++;
        if (sum4 !== 16'h0014 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
          err_cnt++;
          $display("FAIL isolation_result: sum=%h cout=%b ovf=%b, expected 0014 0 0", sum4, cout4, ovf4);
        end
      end
    end
    vec_cnt++;
    if (ndone != 1 || first_n != 5) begin
      err_cnt++;
      $display("FAIL isolation_pulses: count=%0d at n=%0d, expected 1 at n=5", ndone, first_n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(16'h0100, 16'h0200, 1'b0);
    n = 1;
    while (done4 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vec_cnt++;
    if (done4 !== 1'b1 || n != 5 || sum4 !== 16'h0300) begin
      err_cnt++;
      $display("FAIL b2b_first: done=%b n=%0d sum=%h, expected 1 5 0300", done4, n, sum4);
    end
    a = 16'h0005; b = 16'h0006; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vec_cnt++;
    if (busy4 !== 1'b1 || done4 !== 1'b0 || sum4 !== 16'h0300) begin
      err_cnt++;
      $display("FAIL b2b_second_accept: busy=%b done=%b sum=%h, expected 1 0 0300", busy4, done4, sum4);
    end
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (done4 !== 1'b1 || sum4 !== 16'h000B || cout4 !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_second_result: done=%b sum=%h cout=%b, expected 1 000b 0", done4, sum4, cout4);
    end
  endtask

  task automatic test_reset_mid();
    do_start(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      vec_cnt++;
      if (done4 !== 1'b0 || busy4 !== 1'b0 || sum4 !== 16'h0000 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_mid_abort n=%0d: done=%b busy=%b sum=%h cout=%b ovf=%b, expected zeros",
                 n, done4, busy4, sum4, cout4, ovf4);
      end
      @(negedge clk);
    end
    do_start(16'h0007, 16'h0008, 1'b0);
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (done4 !== 1'b1 || sum4 !== 16'h000F) begin
      err_cnt++;
      $display("FAIL reset_mid_restart: done=%b sum=%h, expected 1 000f", done4, sum4);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic [16:0] exp_full;
    logic        exp_ovf;
    int          lat1, lat4, lat16;
    logic [17:0] got1, got4, got16;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0;
    va[1] = 16'h7FFF; vb[1] = 16'h0001; vc[1] = 1'b0;
    va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 1'b0;
    va[3] = 16'h1234; vb[3] = 16'h4321; vc[3] = 1'b1;
    va[4] = 16'h0FFF; vb[4] = 16'h0000; vc[4] = 1'b1;
    for (int i = 5; i < 8; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom_range(1, 0));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_full = {1'b0, va[i]} + {1'b0, vb[i]} + {16'h0000, vc[i]};
      exp_ovf  = (va[i][15] == vb[i][15]) && (exp_full[15] != va[i][15]);
      lat1 = -1; lat4 = -1; lat16 = -1;
      got1 = '0; got4 = '0; got16 = '0;
      do_start(va[i], vb[i], vc[i]);
      for (int n = 1; n <= 20; n++) begin
        if (n > 1) @(negedge clk);
        if (done1 === 1'b1 && lat1 < 0) begin lat1 = n - 1; got1 = {ovf1, cout1, sum1}; end
        if (done4 === 1'b1 && lat4 < 0) begin lat4 = n - 1; got4 = {ovf4, cout4, sum4}; end
        if (done16 === 1'b1 && lat16 < 0) begin lat16 = n - 1; got16 = {ovf16, cout16, sum16}; end
      end
      vec_cnt++;
      if (lat1 != 16 || lat4 != 4 || lat16 != 1) begin
        err_cnt++;
        $display("FAIL sweep_latency #%0d: d1=%0d d4=%0d d16=%0d, expected 16 4 1", i, lat1, lat4, lat16);
      end
      vec_cnt++;
      if (got1 !== {exp_ovf, exp_full} || got4 !== {exp_ovf, exp_full} || got16 !== {exp_ovf, exp_full}) begin
        err_cnt++;
        $display("FAIL sweep_result #%0d a=%h b=%h cin=%b: d1=%h d4=%h d16=%h, expected {ovf,cout,sum}=%h",
                 i, va[i], vb[i], vc[i], got1, got4, got16, {exp_ovf, exp_full});
      end
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    cin   = 1'b0;
    test_reset();
    test_simple();
    test_carry_ripple();
    test_overflow();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
